// File: rtl/q_multibank_buffer_pkg.sv
// Package aura_pkg: shared types and sizing helpers for the Q-vector buffer.
//   qbuf_state_t : per-bank lifecycle state (EMPTY -> FILL -> READY -> EMPTY)
//   Q_ROW_W      : width of one Q vector row
//   Q_NUM_PES    : default rows per bank (one row per PE)
//   QBUF_CNT_W   : width needed to hold a count in the range 0..n
package aura_pkg;

  typedef enum logic [1:0] {
    QB_EMPTY = 2'd0,
    QB_FILL  = 2'd1,
    QB_READY = 2'd2
  } qbuf_state_t;

  localparam int unsigned Q_ROW_W = 512;

  localparam int unsigned Q_NUM_PES = 16;

  function automatic int unsigned QBUF_CNT_W(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/q_multibank_buffer_bank.sv
// qbuf_bank: storage, state, row count and row-valid mask for one buffer bank.
//   clk, rst    : clock, synchronous active-high reset (zeroes storage)
//   clear       : synchronous flush to EMPTY; storage keeps its contents
//   wr_en       : write wr_data into row wr_row
//   wr_close    : the written row closes the bank (goes READY)
//   wr_row      : target row index
//   wr_data     : row data
//   consume     : bank is released by the reader (READY -> EMPTY)
//   state       : current bank state
//   rows        : all rows of the bank
//   mask        : bit i set when row i was written since the last EMPTY
//   count       : number of rows held at close time
module qbuf_bank
   import aura_pkg::*;
#(
   parameter int unsigned NUM_ROWS = Q_NUM_PES,
   parameter int unsigned ROW_W    = Q_ROW_W
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 clear,
   input  logic                                 wr_en,
   input  logic                                 wr_close,
   input  logic [$clog2(NUM_ROWS)-1:0]          wr_row,
   input  logic [ROW_W-1:0]                     wr_data,
   input  logic                                 consume,
   output qbuf_state_t                          state,
   output logic [NUM_ROWS-1:0][ROW_W-1:0]       rows,
   output logic [NUM_ROWS-1:0]                  mask,
   output logic [QBUF_CNT_W(NUM_ROWS)-1:0]      count
);

   localparam int unsigned CW = QBUF_CNT_W(NUM_ROWS);

   always_ff @(posedge clk) begin
      if (rst) begin
         rows  <= '0;
         state <= QB_EMPTY;
         mask  <= '0;
         count <= '0;
      end else if (clear) begin
         state <= QB_EMPTY;
         mask  <= '0;
         count <= '0;
      end else begin
         if (wr_en) begin
            rows[wr_row] <= wr_data;
            mask[wr_row] <= 1'b1;
            if (wr_close) begin
               // A close on row 0 takes EMPTY straight to READY (1-row bank).
               state <= QB_READY;
               count <= CW'(wr_row) + CW'(1);
            end else begin
               state <= QB_FILL;
            end
         end
         // The top never writes and consumes the same bank in one cycle.
         if (consume) begin
            state <= QB_EMPTY;
            mask  <= '0;
         end
      end
   end

endmodule

// File: rtl/q_multibank_buffer.sv
// q_multibank_buffer: NUM_BANKS-deep rotating Q-vector buffer between the
// memory controller and the PE array. Banks fill and drain in strict
// round-robin order; the oldest READY bank presents all rows in parallel.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : synchronous flush; wins over same-cycle handshakes
//   wr_valid    : row offered
//   wr_last     : offered row closes the bank early
//   wr_data     : row data
//   wr_ready    : fill bank can accept a row
//   rd_valid    : read bank is READY
//   rd_ready    : PEs consume and release the read bank
//   rd_data     : all rows of the read bank
//   rd_mask     : row-written mask of the read bank (0 when !rd_valid)
//   rd_count    : rows written in the read bank (0 when !rd_valid)
//   ready_banks : number of READY banks
module q_multibank_buffer
   import aura_pkg::*;
#(
   parameter int unsigned NUM_BANKS = 2,
   parameter int unsigned NUM_ROWS  = Q_NUM_PES,
   parameter int unsigned ROW_W     = Q_ROW_W
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 clear,
   input  logic                                 wr_valid,
   input  logic                                 wr_last,
   input  logic [ROW_W-1:0]                     wr_data,
   output logic                                 wr_ready,
   output logic                                 rd_valid,
   input  logic                                 rd_ready,
   output logic [NUM_ROWS-1:0][ROW_W-1:0]       rd_data,
   output logic [NUM_ROWS-1:0]                  rd_mask,
   output logic [QBUF_CNT_W(NUM_ROWS)-1:0]      rd_count,
   output logic [QBUF_CNT_W(NUM_BANKS)-1:0]     ready_banks
);

   localparam int unsigned PW  = $clog2(NUM_BANKS);
   localparam int unsigned IW  = $clog2(NUM_ROWS);
   localparam int unsigned CW  = QBUF_CNT_W(NUM_ROWS);
   localparam int unsigned RBW = QBUF_CNT_W(NUM_BANKS);

   logic [PW-1:0] fill_ptr;
   logic [PW-1:0] rd_ptr;
   logic [IW-1:0] wr_idx;

   qbuf_state_t                     bank_state [NUM_BANKS];
   logic [NUM_ROWS-1:0][ROW_W-1:0]  bank_rows  [NUM_BANKS];
   logic [NUM_ROWS-1:0]             bank_mask  [NUM_BANKS];
   logic [CW-1:0]                   bank_count [NUM_BANKS];

   logic accept;
   logic close;
   logic consume;

   assign wr_ready = (bank_state[fill_ptr] != QB_READY);
   assign rd_valid = (bank_state[rd_ptr] == QB_READY);

   assign accept  = wr_valid && wr_ready && !clear;
   assign close   = accept && (wr_last || (wr_idx == IW'(NUM_ROWS - 1)));
   assign consume = rd_valid && rd_ready && !clear;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      qbuf_bank #(
         .NUM_ROWS (NUM_ROWS),
         .ROW_W    (ROW_W)
      ) u_bank (
         .clk      (clk),
         .rst      (rst),
         .clear    (clear),
         .wr_en    (accept && (fill_ptr == PW'(b))),
         .wr_close (close),
         .wr_row   (wr_idx),
         .wr_data  (wr_data),
         .consume  (consume && (rd_ptr == PW'(b))),
         .state    (bank_state[b]),
         .rows     (bank_rows[b]),
         .mask     (bank_mask[b]),
         .count    (bank_count[b])
      );
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         fill_ptr    <= '0;
         rd_ptr      <= '0;
         wr_idx      <= '0;
         ready_banks <= '0;
      end else begin
         if (accept) begin
            if (close) begin
               wr_idx   <= '0;
               fill_ptr <= (fill_ptr == PW'(NUM_BANKS - 1)) ? '0 : fill_ptr + PW'(1);
            end else begin
               wr_idx <= wr_idx + IW'(1);
            end
         end
         if (consume) begin
            rd_ptr <= (rd_ptr == PW'(NUM_BANKS - 1)) ? '0 : rd_ptr + PW'(1);
         end
         // Close and consume always target different banks, so both apply.
         case ({close, consume})
            2'b10:   ready_banks <= ready_banks + RBW'(1);
            2'b01:   ready_banks <= ready_banks - RBW'(1);
            default: ready_banks <= ready_banks;
         endcase
      end
   end

   always_comb begin
      rd_data  = bank_rows[rd_ptr];
      rd_mask  = '0;
      rd_count = '0;
      if (rd_valid) begin
         rd_mask  = bank_mask[rd_ptr];
         rd_count = bank_count[rd_ptr];
      end
   end

endmodule

// File: tb/tb_q_multibank_buffer.sv
// Directed bench for q_multibank_buffer with NUM_BANKS=3, NUM_ROWS=4, ROW_W=16.
module tb_q_multibank_buffer;

   localparam int unsigned NB = 3;
   localparam int unsigned NR = 4;
   localparam int unsigned RW = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 clear = 1'b0;
   logic                 wr_valid = 1'b0;
   logic                 wr_last = 1'b0;
   logic [RW-1:0]        wr_data = '0;
   logic                 wr_ready;
   logic                 rd_valid;
   logic                 rd_ready = 1'b0;
   logic [NR-1:0][RW-1:0] rd_data;
   logic [NR-1:0]        rd_mask;
   logic [2:0]           rd_count;
   logic [1:0]           ready_banks;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   q_multibank_buffer #(
      .NUM_BANKS (NB),
      .NUM_ROWS  (NR),
      .ROW_W     (RW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .wr_valid    (wr_valid),
      .wr_last     (wr_last),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .rd_data     (rd_data),
      .rd_mask     (rd_mask),
      .rd_count    (rd_count),
      .ready_banks (ready_banks)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_row(input logic [RW-1:0] d, input logic last);
      wr_valid = 1'b1;
      wr_data  = d;
      wr_last  = last;
      tick();
      wr_valid = 1'b0;
      wr_last  = 1'b0;
   endtask

   task automatic consume_one();
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
   endtask

   logic [63:0] sb [$];
   logic [63:0] cur;
   int          rows_sent;
   int          row_in;
   int          banks_read;
   int          cycles;

   initial begin
      // Reset
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_rd_valid", rd_valid, 0);
      check("rst_wr_ready", wr_ready, 1);
      check("rst_rd_mask", rd_mask, 0);
      check("rst_rd_count", rd_count, 0);
      check("rst_ready_banks", ready_banks, 0);

      // Test 1: one full bank
      write_row(16'hA0, 1'b0);
      write_row(16'hA1, 1'b0);
      write_row(16'hA2, 1'b0);
      check("t1_not_yet_valid", rd_valid, 0);
      write_row(16'hA3, 1'b0);
      check("t1_rd_valid", rd_valid, 1);
      check("t1_rd_count", rd_count, 4);
      check("t1_rd_mask", rd_mask, 4'b1111);
      check("t1_rd_data2", rd_data[2], 16'hA2);

      // Test 2: fill all banks, overflow attempt ignored
      for (int i = 0; i < 4; i++) write_row(16'(16'hB0 + i), 1'b0);
      for (int i = 0; i < 4; i++) write_row(16'(16'hC0 + i), 1'b0);
      check("t2_wr_ready_full", wr_ready, 0);
      check("t2_ready_banks3", ready_banks, 3);
      write_row(16'hDD, 1'b0);
      check("t2_ignored_ready_banks", ready_banks, 3);
      check("t2_ignored_wr_ready", wr_ready, 0);
      check("t2_bank0_row0", rd_data[0], 16'hA0);
      consume_one();
      check("t2_bank1_row0", rd_data[0], 16'hB0);
      check("t2_ready_banks2", ready_banks, 2);
      check("t2_wr_ready_freed", wr_ready, 1);
      consume_one();
      check("t2_bank2_row3", rd_data[3], 16'hC3);
      check("t2_ready_banks1", ready_banks, 1);
      consume_one();
      check("t2_drained_valid", rd_valid, 0);
      check("t2_drained_banks", ready_banks, 0);
      check("t2_drained_mask", rd_mask, 0);
      check("t2_drained_count", rd_count, 0);

      // Test 3: early close, degenerate 1-row close
      write_row(16'h30, 1'b0);
      write_row(16'h31, 1'b1);
      check("t3_rd_count", rd_count, 2);
      check("t3_rd_mask", rd_mask, 4'b0011);
      check("t3_rd_data1", rd_data[1], 16'h31);
      check("t3_stale_row2", rd_data[2], 16'hA2);
      write_row(16'h40, 1'b1);
      check("t3_ready_banks2", ready_banks, 2);
      consume_one();
      check("t3_bank1_count", rd_count, 1);
      check("t3_bank1_mask", rd_mask, 4'b0001);
      check("t3_bank1_row0", rd_data[0], 16'h40);
      consume_one();
      check("t3_empty", rd_valid, 0);

      // Test 5: clear mid-fill together with write and read handshakes
      write_row(16'h50, 1'b0);
      clear    = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 16'h51;
      rd_ready = 1'b1;
      tick();
      clear    = 1'b0;
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      check("t5_rd_valid", rd_valid, 0);
      check("t5_wr_ready", wr_ready, 1);
      check("t5_ready_banks", ready_banks, 0);
      check("t5_rd_mask", rd_mask, 0);
      check("t5_rd_count", rd_count, 0);
      write_row(16'h60, 1'b1);
      check("t5_ptrs_reset_valid", rd_valid, 1);
      check("t5_bank0_row0", rd_data[0], 16'h60);
      check("t5_stale_row1", rd_data[1], 16'h31);
      check("t5_mask", rd_mask, 4'b0001);

      // Test 4: close bank 1 while bank 0 is consumed
      write_row(16'h70, 1'b0);
      wr_valid = 1'b1;
      wr_data  = 16'h71;
      wr_last  = 1'b1;
      rd_ready = 1'b1;
      tick();
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      rd_ready = 1'b0;
      check("t4_rd_valid", rd_valid, 1);
      check("t4_ready_banks", ready_banks, 1);
      check("t4_bank1_row0", rd_data[0], 16'h70);
      check("t4_bank1_row1", rd_data[1], 16'h71);
      check("t4_count", rd_count, 2);
      consume_one();
      check("t4_empty", rd_valid, 0);

      // Test 6: five wraps of full banks with random consumption
      rows_sent  = 0;
      row_in     = 0;
      banks_read = 0;
      cycles     = 0;
      cur        = '0;
      while (banks_read < 5 * NB && cycles < 3000) begin
         wr_valid = (rows_sent < 5 * NB * NR);
         wr_data  = 16'(16'h1000 + rows_sent);
         wr_last  = 1'b0;
         rd_ready = (rows_sent >= 5 * NB * NR) ? 1'b1 : 1'($urandom_range(0, 1));
         if (rd_valid && rd_ready) begin
            if (sb.size() == 0) begin
               check("t6_extra_bank", 1, 0);
            end else begin
               check("t6_bank_data", rd_data, sb.pop_front());
               banks_read++;
            end
         end
         if (wr_valid && wr_ready) begin
            cur[row_in*RW +: RW] = wr_data;
            row_in++;
            rows_sent++;
            if (row_in == NR) begin
               sb.push_back(cur);
               row_in = 0;
            end
         end
         tick();
         cycles++;
         check("t6_ready_banks", ready_banks, 64'(sb.size()));
      end
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      check("t6_banks_read", banks_read, 5 * NB);
      check("t6_sb_empty", sb.size(), 0);
      #1;
      check("t6_final_valid", rd_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
